// File: rtl/sha3_digest_axis_tx.sv
// Captures the leading 8 lanes of the final Keccak state and streams the truncated
// SHA-3 digest as 16-bit AXI-Stream beats. Optional feature macro: DIGEST_OVERRUN_EN.
module sha3_digest_axis_tx #(
  parameter int TDATA_W = 16,
  parameter int TID_W   = 2
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [0:4][0:4][63:0]   state_in,
  input  logic                    hash_valid,
  output logic                    hash_ready,
  input  logic [TID_W-1:0]        ID,
  output logic [TDATA_W-1:0]      TDATA,
  output logic                    TVALID,
  input  logic                    TREADY,
  output logic                    TLAST,
  output logic [TID_W-1:0]        TID,
`ifdef DIGEST_OVERRUN_EN
  output logic                    overrun,
`endif
  output logic                    busy
);

  generate
    if (TDATA_W != 16) begin : g_bad_tdata_w
      $error("sha3_digest_axis_tx: only TDATA_W=16 is supported");
    end
    if (TID_W < 2) begin : g_bad_tid_w
      $error("sha3_digest_axis_tx: TID_W must be at least 2");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state_reg;
  logic [511:0] digest_reg;
  logic [4:0]   cnt_reg;
  logic [4:0]   last_reg;
  logic [511:0] cap_lanes;

  // Digest lane i is lane (x=i%5, y=i/5); lane 0 sits in the low 64 bits.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign cap_lanes[64*gi +: 64] = state_in[gi % 5][gi / 5];
    end
  endgenerate

  // Beat k covers digest bits [16k+15:16k]; the lower byte goes out first in TDATA[15:8].
  function automatic logic [15:0] beat_of(input logic [511:0] d, input logic [4:0] k);
    logic [8:0] base;
    base = {k, 4'd0};
    return {d[base +: 8], d[base + 9'd8 +: 8]};
  endfunction

  function automatic logic [4:0] last_idx(input logic [1:0] mode);
    case (mode)
      2'd0:    return 5'd13;
      2'd1:    return 5'd15;
      2'd2:    return 5'd23;
      default: return 5'd31;
    endcase
  endfunction

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg  <= IDLE;
      digest_reg <= '0;
      cnt_reg    <= '0;
      last_reg   <= '0;
      hash_ready <= 1'b1;
      TVALID     <= 1'b0;
      TLAST      <= 1'b0;
      TDATA      <= '0;
      TID        <= '0;
      busy       <= 1'b0;
`ifdef DIGEST_OVERRUN_EN
      overrun    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (hash_valid) begin
            digest_reg <= cap_lanes;
            TID        <= ID;
            last_reg   <= last_idx(ID[1:0]);
            cnt_reg    <= '0;
            TDATA      <= beat_of(cap_lanes, 5'd0);
            TVALID     <= 1'b1;
            TLAST      <= 1'b0;
            hash_ready <= 1'b0;
            busy       <= 1'b1;
            state_reg  <= SEND;
          end
        end
        SEND: begin
          // TVALID is constantly high here, so TREADY alone marks a handshake.
          if (TREADY) begin
            if (cnt_reg == last_reg) begin
              TVALID     <= 1'b0;
              TLAST      <= 1'b0;
              hash_ready <= 1'b1;
              busy       <= 1'b0;
              state_reg  <= IDLE;
            end else begin
              cnt_reg <= cnt_reg + 5'd1;
              TDATA   <= beat_of(digest_reg, cnt_reg + 5'd1);
              TLAST   <= ((cnt_reg + 5'd1) == last_reg);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
`ifdef DIGEST_OVERRUN_EN
      if (state_reg == IDLE && hash_valid)
        overrun <= 1'b0;
      else if (busy && hash_valid)
        overrun <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_sha3_digest_axis_tx.sv
// Randomised bench for sha3_digest_axis_tx: a byte-stream digest model plus literal
// SHA3-224/256 empty-message vectors.
module tb_sha3_digest_axis_tx;

  logic                  ACLK = 1'b0;
  logic                  ARESET;
  logic [0:4][0:4][63:0] state_in;
  logic                  hash_valid;
  logic                  hash_ready;
  logic [1:0]            ID;
  logic [15:0]           TDATA;
  logic                  TVALID;
  logic                  TREADY;
  logic                  TLAST;
  logic [1:0]            TID;
  logic                  busy;
`ifdef DIGEST_OVERRUN_EN
  logic                  overrun;
`endif

  sha3_digest_axis_tx #(.TDATA_W(16), .TID_W(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .state_in(state_in), .hash_valid(hash_valid),
    .hash_ready(hash_ready), .ID(ID), .TDATA(TDATA), .TVALID(TVALID), .TREADY(TREADY),
    .TLAST(TLAST), .TID(TID),
`ifdef DIGEST_OVERRUN_EN
    .overrun(overrun),
`endif
    .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: the digest is a byte stream (lanes L0.. little-endian), two bytes per beat.
  logic [15:0] m_beats [32];
  int          m_n = 0;
  int          m_idx = 0;
  bit          m_active = 0;
  bit          m_fresh = 1;
  bit          m_ovr = 0;
  logic [1:0]  m_tid = 0;

  function automatic int n_of(input logic [1:0] mode);
    case (mode)
      2'd0:    return 14;
      2'd1:    return 16;
      2'd2:    return 24;
      default: return 32;
    endcase
  endfunction

  always @(posedge ACLK) begin
    cyc++;
    if (ARESET) begin
      m_active = 0; m_idx = 0; m_tid = 0; m_fresh = 1; m_ovr = 0;
    end else if (!m_active) begin
      if (hash_valid) begin
        logic [7:0] bytes_ [64];
        for (int i = 0; i < 64; i++)
          bytes_[i] = state_in[(i/8) % 5][(i/8) / 5][8*(i%8) +: 8];
        for (int k = 0; k < 32; k++)
          m_beats[k] = {bytes_[2*k], bytes_[2*k+1]};
        m_n = n_of(ID); m_tid = ID; m_idx = 0;
        m_active = 1; m_fresh = 0; m_ovr = 0;
      end
    end else begin
      if (hash_valid) m_ovr = 1;
      if (TREADY) begin
        m_idx++;
        if (m_idx == m_n) m_active = 0;
      end
    end
  end

  // Received stream, for the literal vectors and timing checks.
  logic [15:0] rx [$];
  bit          rx_last [$];
  int          rx_cyc [$];

  always @(negedge ACLK) begin
    check("tvalid", {31'd0, TVALID}, {31'd0, m_active});
    check("hash_ready", {31'd0, hash_ready}, {31'd0, !m_active});
    check("busy", {31'd0, busy}, {31'd0, m_active});
`ifdef DIGEST_OVERRUN_EN
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
`endif
    if (m_active) begin
      check("tdata", {16'd0, TDATA}, {16'd0, m_beats[m_idx]});
      check("tlast", {31'd0, TLAST}, {31'd0, (m_idx == m_n - 1)});
      check("tid", {30'd0, TID}, {30'd0, m_tid});
    end else if (m_fresh) begin
      check("reset_tdata", {16'd0, TDATA}, 32'd0);
      check("reset_tlast", {31'd0, TLAST}, 32'd0);
      check("reset_tid", {30'd0, TID}, 32'd0);
    end else begin
      check("idle_tlast", {31'd0, TLAST}, 32'd0);
    end
    if (TVALID && TREADY) begin
      rx.push_back(TDATA); rx_last.push_back(TLAST); rx_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic random_state();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        state_in[x][y] = {$urandom, $urandom};
  endtask

  // v holds the digest big-endian, left-aligned: byte i = v[511-8i -: 8].
  task automatic load_digest(input logic [511:0] v, input int nbytes);
    random_state();
    for (int i = 0; i < nbytes; i++)
      state_in[(i/8) % 5][(i/8) / 5][8*(i%8) +: 8] = v[511-8*i -: 8];
  endtask

  task automatic capture(input logic [1:0] mode);
    ID = mode; hash_valid = 1'b1;
    tick();
    hash_valid = 1'b0;
  endtask

  task automatic clear_rx();
    rx.delete(); rx_last.delete(); rx_cyc.delete();
  endtask

  initial begin
    ARESET = 1'b1; hash_valid = 1'b0; TREADY = 1'b1; ID = 2'd0;
    random_state();
    repeat (3) tick();
    ARESET = 1'b0;
    tick();

    // SHA3-256("")
    clear_rx();
    load_digest({256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a, 256'd0}, 32);
    capture(2'd1);
    repeat (20) tick();
    check("s256_count", rx.size(), 32'd16);
    if (rx.size() == 16) begin
      check("s256_beat0", {16'd0, rx[0]}, 32'ha7ff);
      check("s256_beat1", {16'd0, rx[1]}, 32'hc6f8);
      check("s256_beat2", {16'd0, rx[2]}, 32'hbf1e);
      check("s256_beat15", {16'd0, rx[15]}, 32'h434a);
      check("s256_last15", {31'd0, rx_last[15]}, 32'd1);
      check("s256_last14", {31'd0, rx_last[14]}, 32'd0);
      check("s256_span", rx_cyc[15] - rx_cyc[0], 32'd15);
    end

    // SHA3-224("")
    clear_rx();
    load_digest({224'h6b4e03423667dbb73b6e15454f0eb1abd4597f9a1b078e3f5b5a6bc7, 288'd0}, 28);
    capture(2'd0);
    repeat (20) tick();
    check("s224_count", rx.size(), 32'd14);
    if (rx.size() == 14) begin
      check("s224_beat0", {16'd0, rx[0]}, 32'h6b4e);
      check("s224_beat1", {16'd0, rx[1]}, 32'h0342);
      check("s224_beat13", {16'd0, rx[13]}, 32'h6bc7);
      check("s224_last13", {31'd0, rx_last[13]}, 32'd1);
    end

    // SHA3-512 length with random backpressure
    clear_rx();
    random_state();
    capture(2'd3);
    for (int i = 0; i < 400 && m_active; i++) begin
      TREADY = ($urandom_range(0, 1) == 1);
      tick();
    end
    TREADY = 1'b1;
    repeat (3) tick();
    check("s512_count", rx.size(), 32'd32);

    // hash_valid with new state at beat 5 is ignored
    clear_rx();
    random_state();
    capture(2'd2);
    repeat (4) tick();
    random_state();
    capture(2'd0);
    repeat (30) tick();
    check("drop_count", rx.size(), 32'd24);

    // Reset in the middle of a digest, then a clean capture
    random_state();
    capture(2'd1);
    repeat (7) tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    clear_rx();
    tick();
    random_state();
    capture(2'd1);
    repeat (20) tick();
    check("post_reset_count", rx.size(), 32'd16);

    // Back-to-back with hash_valid held high
    clear_rx();
    random_state();
    ID = 2'd1; hash_valid = 1'b1;
    repeat (36) tick();
    hash_valid = 1'b0;
    repeat (20) tick();
    check("b2b_enough", {31'd0, (rx.size() >= 32)}, 32'd1);
    if (rx.size() >= 17) begin
      check("b2b_last", {31'd0, rx_last[15]}, 32'd1);
      check("b2b_gap", rx_cyc[16] - rx_cyc[15], 32'd2);
    end

    // Randomised soak
    for (int i = 0; i < 3000; i++) begin
      TREADY     = ($urandom_range(0, 3) != 0);
      hash_valid = ($urandom_range(0, 7) == 0);
      ID         = 2'($urandom_range(0, 3));
      ARESET     = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) random_state();
      tick();
    end
    ARESET = 1'b0; hash_valid = 1'b0; TREADY = 1'b1;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
